mic1_mem_ctrl: RTL

Memory controller for the Mic-1 dual-port main memory (port A read/write, port B read-only, both with one-cycle registered reads). It arbitrates port A between the datapath word interface (MAR/MDR) and a debug/loader interface. It sequences port B for instruction fetch (PC/MBR). It also rejects out-of-range addresses before they reach the array.

---
 rtl/mic1_mem_if.sv | 50 +++++
 rtl/mic1_mem_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mic1_mem_if.sv
// Signal bundle between the Mic-1 memory controller and its clients:
// datapath word port, instruction fetch port, debug/loader port and the dual-port array.
interface mic1_mem_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
);
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr_out;
  logic [DATA_W-1:0] mdr_in;
  logic              dp_done;

  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] mbr;
  logic              fetch_done;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              addr_err;

  logic              mem_wen_A;
  logic              mem_ren_A;
  logic              mem_ren_B;
  logic [ADDR_W-1:0] mem_addr_A;
  logic [ADDR_W-1:0] mem_addr_B;
  logic [DATA_W-1:0] mem_wdata_A;
  logic [DATA_W-1:0] mem_rdata_A;
  logic [DATA_W-1:0] mem_rdata_B;

  modport slave (
    input  rd_req, wr_req, mar, mdr_out, fetch_req, pc,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata_A, mem_rdata_B,
    output mdr_in, dp_done, mbr, fetch_done, dbg_rdata, dbg_ack, addr_err,
           mem_wen_A, mem_ren_A, mem_ren_B, mem_addr_A, mem_addr_B, mem_wdata_A
  );

  modport master (
    output rd_req, wr_req, mar, mdr_out, fetch_req, pc,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata_A, mem_rdata_B,
    input  mdr_in, dp_done, mbr, fetch_done, dbg_rdata, dbg_ack, addr_err,
           mem_wen_A, mem_ren_A, mem_ren_B, mem_addr_A, mem_addr_B, mem_wdata_A
  );
endinterface

// File: rtl/mic1_mem_ctrl.sv
// Mic-1 main memory controller: port A shared by datapath and debug (round-robin),
// port B dedicated to instruction fetch; out-of-range addresses never strobe the array.
//
// state  | meaning
// A_IDLE | arbitrate datapath vs debug
// A_WR   | mem_wen_A asserted for one cycle
// A_RD   | mem_ren_A asserted for one cycle
// A_CAP  | array output settling
// A_DONE | read data captured, done/ack pulse
// B_IDLE | wait for fetch_req
// B_RD   | mem_ren_B asserted for one cycle
// B_CAP  | array output settling, mbr loaded on exit
module mic1_mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9,
  parameter int DEPTH  = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  mic1_mem_if.slave bus
);

  typedef enum logic [2:0] {A_IDLE, A_WR, A_RD, A_CAP, A_DONE} a_state_t;
  typedef enum logic [1:0] {B_IDLE, B_RD, B_CAP} b_state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  a_state_t          a_state_q;
  b_state_t          b_state_q;
  logic              a_dbg_q;
  logic              a_err_q;
  logic              b_err_q;
  logic              rr_dbg_q;
  logic              dp_done_q;
  logic              dbg_ack_q;
  logic              fetch_done_q;
  logic              addr_err_q;
  logic              mem_wen_a_q;
  logic              mem_ren_a_q;
  logic              mem_ren_b_q;
  logic [ADDR_W-1:0] mem_addr_a_q;
  logic [ADDR_W-1:0] mem_addr_b_q;
  logic [DATA_W-1:0] mem_wdata_a_q;
  logic [DATA_W-1:0] mdr_in_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [DATA_W-1:0] mbr_q;

  logic              dp_any;
  logic              grant_dp;
  logic              grant_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              a_in_range;
  logic              b_in_range;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;

  assign dp_any     = bus.rd_req | bus.wr_req;
  assign grant_dp   = dp_any & (~bus.dbg_req | ~rr_dbg_q);
  assign grant_dbg  = bus.dbg_req & ~grant_dp;
  // A datapath request with both rd_req and wr_req high is treated as a write.
  assign sel_we     = grant_dp ? bus.wr_req : bus.dbg_we;
  assign sel_addr   = grant_dp ? bus.mar : bus.dbg_addr;
  assign sel_wdata  = grant_dp ? bus.mdr_out : bus.dbg_wdata;
  assign a_in_range = {1'b0, sel_addr} < DEPTH_W;
  assign b_in_range = {1'b0, bus.pc} < DEPTH_W;
  assign a_rdata    = a_err_q ? '0 : bus.mem_rdata_A;
  assign b_rdata    = b_err_q ? '0 : bus.mem_rdata_B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_q     <= A_IDLE;
      a_dbg_q       <= 1'b0;
      a_err_q       <= 1'b0;
      rr_dbg_q      <= 1'b0;
      dp_done_q     <= 1'b0;
      dbg_ack_q     <= 1'b0;
      mem_wen_a_q   <= 1'b0;
      mem_ren_a_q   <= 1'b0;
      mem_addr_a_q  <= '0;
      mem_wdata_a_q <= '0;
      mdr_in_q      <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      dp_done_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      mem_wen_a_q <= 1'b0;
      mem_ren_a_q <= 1'b0;
      case (a_state_q)
        A_IDLE: begin
          if (grant_dp || grant_dbg) begin
            a_dbg_q  <= grant_dbg;
            a_err_q  <= ~a_in_range;
            rr_dbg_q <= grant_dp;
            if (a_in_range) mem_addr_a_q <= sel_addr;
            if (sel_we) begin
              a_state_q   <= A_WR;
              mem_wen_a_q <= a_in_range;
              if (a_in_range) mem_wdata_a_q <= sel_wdata;
            end else begin
              a_state_q   <= A_RD;
              mem_ren_a_q <= a_in_range;
            end
          end
        end
        A_WR: begin
          a_state_q <= A_DONE;
          dp_done_q <= ~a_dbg_q;
          dbg_ack_q <= a_dbg_q;
        end
        A_RD: a_state_q <= A_CAP;
        A_CAP: begin
          a_state_q <= A_DONE;
          dp_done_q <= ~a_dbg_q;
          dbg_ack_q <= a_dbg_q;
          if (a_dbg_q) dbg_rdata_q <= a_rdata;
          else         mdr_in_q    <= a_rdata;
        end
        A_DONE:  a_state_q <= A_IDLE;
        default: a_state_q <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q    <= B_IDLE;
      b_err_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      mem_ren_b_q  <= 1'b0;
      mem_addr_b_q <= '0;
      mbr_q        <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      mem_ren_b_q  <= 1'b0;
      case (b_state_q)
        B_IDLE: begin
          if (bus.fetch_req) begin
            b_state_q   <= B_RD;
            b_err_q     <= ~b_in_range;
            mem_ren_b_q <= b_in_range;
            if (b_in_range) mem_addr_b_q <= bus.pc;
          end
        end
        B_RD: b_state_q <= B_CAP;
        B_CAP: begin
          b_state_q    <= B_IDLE;
          fetch_done_q <= 1'b1;
          mbr_q        <= b_rdata;
        end
        default: b_state_q <= B_IDLE;
      endcase
    end
  end

  // Both ports can finish in the same cycle, so their range errors are merged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= (((a_state_q == A_WR) || (a_state_q == A_CAP)) && a_err_q) ||
                    ((b_state_q == B_CAP) && b_err_q);
    end
  end

  assign bus.mdr_in      = mdr_in_q;
  assign bus.dp_done     = dp_done_q;
  assign bus.mbr         = mbr_q;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.dbg_ack     = dbg_ack_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.mem_wen_A   = mem_wen_a_q;
  assign bus.mem_ren_A   = mem_ren_a_q;
  assign bus.mem_ren_B   = mem_ren_b_q;
  assign bus.mem_addr_A  = mem_addr_a_q;
  assign bus.mem_addr_B  = mem_addr_b_q;
  assign bus.mem_wdata_A = mem_wdata_a_q;

endmodule
